// File: rtl/rifl_sync_pkg.sv
// Shared constants and helpers for the rifl_sync_bank CDC receiver.
// Optional feature macro used by this block: RIFL_SYNC_EVENT_CNT_EN.
package rifl_sync_pkg;

  // Shortest chain that still gives a metastable first stage a full cycle to resolve.
  localparam int MIN_SYNC_STAGES = 2;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Legal parameter combination for a bank.
  function automatic bit params_ok(input int num_ch, input int sync_stages,
                                   input int filter_len, input int cnt_w);
    return (num_ch >= 1) && (sync_stages >= MIN_SYNC_STAGES) &&
           (filter_len >= 1) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/rifl_sync_chan.sv
// One receiver channel: metastability chain, optional glitch filter, stable
// register, edge strobes and (with RIFL_SYNC_EVENT_CNT_EN) a saturating
// event counter.
module rifl_sync_chan
  import rifl_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter bit FILTER_EN   = 1'b0,
  parameter bit TOGGLE      = 1'b0,
  parameter bit RST_BIT     = 1'b0
`ifdef RIFL_SYNC_EVENT_CNT_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             async_in,
  output logic             sync_out,
  output logic             evt_pulse,
  output logic             fall_pulse
`ifdef RIFL_SYNC_EVENT_CNT_EN
  , input  logic             evt_cnt_clr
  , output logic [CNT_W-1:0] evt_cnt
`endif
);

  // An unfiltered channel is a filtered one that accepts after a single
  // mismatching cycle, so one datapath serves both and the counter folds away.
  localparam int EFF_LEN = FILTER_EN ? FILTER_LEN : 1;
  localparam int CW      = clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(EFF_LEN - 1);

  logic [SYNC_STAGES-1:0] r_chain;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_evt;
  logic                   r_fall;
  logic                   w_sq;
  logic                   w_mismatch;
  logic                   w_accept;

  assign w_sq       = r_chain[SYNC_STAGES-1];
  assign w_mismatch = (w_sq != r_stable);
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  // Metastability chain: pure shift register, nothing between stages.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: every chain stage is reset to the channel's reset value, not left
    // as an unreset shift memory; otherwise stale stages would fake an edge
    // right after reset release.
    if (!rst_n_in) begin
      r_chain <= {SYNC_STAGES{RST_BIT}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], async_in};
    end
  end

  // Filter, stable value and strobes, all updated together so a strobe marks
  // exactly the cycle the new stable value first appears.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: non-blocking assignments throughout, so every right-hand side reads
    // the pre-edge value and the statement order does not matter.
    if (!rst_n_in) begin
      r_cnt    <= '0;
      r_stable <= RST_BIT;
      r_evt    <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_evt  <= 1'b0;
      r_fall <= 1'b0;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt    <= '0;
        r_stable <= w_sq;
        r_evt    <= TOGGLE ? 1'b1 : w_sq;
        r_fall   <= TOGGLE ? 1'b0 : ~w_sq;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sync_out   = r_stable;
  assign evt_pulse  = r_evt;
  assign fall_pulse = r_fall;

`ifdef RIFL_SYNC_EVENT_CNT_EN
  logic [CNT_W-1:0] r_evt_cnt;

  // Saturating event counter; a clear wins over a same-cycle event.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_evt_cnt <= '0;
    end else if (evt_cnt_clr) begin
      r_evt_cnt <= '0;
    end else if (r_evt && !(&r_evt_cnt)) begin
      r_evt_cnt <= r_evt_cnt + 1'b1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`endif

endmodule

// File: rtl/rifl_sync_bank.sv
// Multi-channel CDC receiver bank for one destination clock domain.
// Optional per-channel event counters are built when RIFL_SYNC_EVENT_CNT_EN
// is defined; otherwise evt_cnt_clr/evt_cnt and the counters do not exist.
module rifl_sync_bank
  import rifl_sync_pkg::*;
#(
  parameter int                NUM_CH      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter int                FILTER_LEN  = 4,
  parameter logic [NUM_CH-1:0] FILTER_MASK = '0,
  parameter logic [NUM_CH-1:0] TOGGLE_MASK = '0,
  parameter logic [NUM_CH-1:0] RST_VAL     = '0,
  parameter int                CNT_W       = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       sync_out,
  output logic [NUM_CH-1:0]       evt_pulse,
  output logic [NUM_CH-1:0]       fall_pulse,
  output logic                    any_evt
`ifdef RIFL_SYNC_EVENT_CNT_EN
  , input  logic                    evt_cnt_clr
  , output logic [NUM_CH*CNT_W-1:0] evt_cnt
`endif
);

  if (!params_ok(NUM_CH, SYNC_STAGES, FILTER_LEN, CNT_W)) begin : g_bad_params
    $error("rifl_sync_bank: illegal NUM_CH/SYNC_STAGES/FILTER_LEN/CNT_W");
  end

  logic [NUM_CH-1:0] w_evt;
  logic [NUM_CH-1:0] w_fall;
  logic              r_any_evt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rifl_sync_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .FILTER_EN   (FILTER_MASK[i]),
      .TOGGLE      (TOGGLE_MASK[i]),
      .RST_BIT     (RST_VAL[i])
`ifdef RIFL_SYNC_EVENT_CNT_EN
      , .CNT_W     (CNT_W)
`endif
    ) u_chan (
      .clk_in      (clk_in),
      .rst_n_in    (rst_n_in),
      .async_in    (async_in[i]),
      .sync_out    (sync_out[i]),
      .evt_pulse   (w_evt[i]),
      .fall_pulse  (w_fall[i])
`ifdef RIFL_SYNC_EVENT_CNT_EN
      , .evt_cnt_clr (evt_cnt_clr)
      , .evt_cnt     (evt_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

  // Summary strobe, one cycle behind the per-channel strobes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_any_evt <= 1'b0;
    end else begin
      r_any_evt <= |(w_evt | w_fall);
    end
  end

  assign evt_pulse  = w_evt;
  assign fall_pulse = w_fall;
  assign any_evt    = r_any_evt;

endmodule

// File: tb/tb_rifl_sync_bank.sv
// Self-checking bench for rifl_sync_bank: 4 channels, 3-stage chains,
// ch0/ch1 unfiltered level, ch2 filtered level, ch3 toggle event.
module tb_rifl_sync_bank;

  localparam int         NCH   = 4;
  localparam int         S     = 3;
  localparam int         FL    = 4;
  localparam int         CW    = 4;
  localparam logic [3:0] FMASK = 4'b0100;
  localparam logic [3:0] TMASK = 4'b1000;
  localparam logic [3:0] RSTV  = 4'b0010;

  logic           clk_in   = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [NCH-1:0] async_in = 4'b1101;
  logic [NCH-1:0] sync_out;
  logic [NCH-1:0] evt_pulse;
  logic [NCH-1:0] fall_pulse;
  logic           any_evt;
`ifdef RIFL_SYNC_EVENT_CNT_EN
  logic              evt_cnt_clr = 1'b0;
  logic [NCH*CW-1:0] evt_cnt;
  logic [CW-1:0]     m_cnt [NCH];
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: input history, s_q history, stable value and strobes.
  logic [3:0] samp [$];
  logic [3:0] sqh  [$];
  logic [3:0] m_stable;
  logic [3:0] m_evt;
  logic [3:0] m_fall;
  logic       m_any;

  rifl_sync_bank #(
    .NUM_CH      (NCH),
    .SYNC_STAGES (S),
    .FILTER_LEN  (FL),
    .FILTER_MASK (FMASK),
    .TOGGLE_MASK (TMASK),
    .RST_VAL     (RSTV),
    .CNT_W       (CW)
  ) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .async_in    (async_in),
    .sync_out    (sync_out),
    .evt_pulse   (evt_pulse),
    .fall_pulse  (fall_pulse),
    .any_evt     (any_evt)
`ifdef RIFL_SYNC_EVENT_CNT_EN
    , .evt_cnt_clr (evt_cnt_clr)
    , .evt_cnt     (evt_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    m_stable = RSTV;
    m_evt    = '0;
    m_fall   = '0;
    m_any    = 1'b0;
    samp.delete();
    sqh.delete();
    sqh.push_back(RSTV);
`ifdef RIFL_SYNC_EVENT_CNT_EN
    for (int i = 0; i < NCH; i++) m_cnt[i] = '0;
`endif
  endtask

  // One destination edge. A channel flips once its last len s_q samples all
  // disagree with the current stable value (len = FL if filtered, else 1).
  task automatic model_step();
    logic [3:0] nxt;
    logic [3:0] sq;
    bit         all_diff;
    int         len;
    int         idx;
    logic       v;
`ifdef RIFL_SYNC_EVENT_CNT_EN
    for (int i = 0; i < NCH; i++) begin
      if (evt_cnt_clr) m_cnt[i] = '0;
      else if (m_evt[i] && m_cnt[i] != 4'hF) m_cnt[i] = m_cnt[i] + 4'd1;
    end
`endif
    m_any = |(m_evt | m_fall);
    nxt = m_stable;
    for (int i = 0; i < NCH; i++) begin
      len = FMASK[i] ? FL : 1;
      all_diff = 1'b1;
      for (int k = 0; k < len; k++) begin
        idx = sqh.size() - 1 - k;
        v = (idx >= 0) ? sqh[idx][i] : RSTV[i];
        if (v == m_stable[i]) all_diff = 1'b0;
      end
      if (all_diff) nxt[i] = ~m_stable[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (TMASK[i]) begin
        m_evt[i]  = nxt[i] ^ m_stable[i];
        m_fall[i] = 1'b0;
      end else begin
        m_evt[i]  = nxt[i] & ~m_stable[i];
        m_fall[i] = m_stable[i] & ~nxt[i];
      end
    end
    m_stable = nxt;
    samp.push_back(async_in);
    if (samp.size() > S) void'(samp.pop_front());
    sq = (samp.size() == S) ? samp[0] : RSTV;
    sqh.push_back(sq);
    if (sqh.size() > 8) void'(sqh.pop_front());
  endtask

  // Advance one clock; returns at the following falling edge (sample point).
  task automatic tick();
    @(posedge clk_in);
    if (rst_n_in) model_step();
    @(negedge clk_in);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    async_in = 4'b1101;
    model_reset();
    repeat (3) @(negedge clk_in);
    n_checks++;
    if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {RSTV, 4'b0, 4'b0, 1'b0})
      $display("FAIL reset_state: got %b/%b/%b/%b expected %b/0000/0000/0",
               sync_out, evt_pulse, fall_pulse, any_evt, RSTV);
    else n_pass++;
    rst_n_in = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e <= S) begin
        n_checks++;
        if (sync_out !== RSTV)
          $display("FAIL release_hold e%0d: got %b expected %b", e, sync_out, RSTV);
        else n_pass++;
      end
      if (e == 1) begin
        n_checks++;
        if ((evt_pulse | fall_pulse) !== 4'b0)
          $display("FAIL release_no_pulse: got evt %b fall %b expected 0", evt_pulse, fall_pulse);
        else n_pass++;
      end
      if (e == S + 1) begin
        n_checks++;
        if ((sync_out & ~FMASK) !== (4'b1101 & ~FMASK))
          $display("FAIL release_unfiltered: got %b expected %b", sync_out & ~FMASK, 4'b1101 & ~FMASK);
        else n_pass++;
      end
      if (e == S + FL) begin
        n_checks++;
        if (sync_out !== 4'b1101)
          $display("FAIL release_filtered: got %b expected 1101", sync_out);
        else n_pass++;
      end
      n_checks++;
      if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
        $display("FAIL reset_model e%0d: got %b expected %b", e,
                 {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
      else n_pass++;
    end
  endtask

  task automatic test_level();
    async_in[0] = 1'b0;
    repeat (6) tick();
    async_in[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == S + 1) begin
        n_checks++;
        if (!(sync_out[0] === 1'b1 && evt_pulse[0] === 1'b1 && any_evt === 1'b0))
          $display("FAIL rise_edge: got sync %b evt %b any %b expected 1 1 0",
                   sync_out[0], evt_pulse[0], any_evt);
        else n_pass++;
      end
      if (e == S + 2) begin
        n_checks++;
        if (!(evt_pulse[0] === 1'b0 && any_evt === 1'b1))
          $display("FAIL rise_any_evt: got evt %b any %b expected 0 1", evt_pulse[0], any_evt);
        else n_pass++;
      end
    end
    async_in[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == S + 1) begin
        n_checks++;
        if (!(sync_out[0] === 1'b0 && fall_pulse[0] === 1'b1 && evt_pulse[0] === 1'b0))
          $display("FAIL fall_edge: got sync %b fall %b evt %b expected 0 1 0",
                   sync_out[0], fall_pulse[0], evt_pulse[0]);
        else n_pass++;
      end
      n_checks++;
      if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
        $display("FAIL level_model e%0d: got %b expected %b", e,
                 {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
      else n_pass++;
    end
  endtask

  task automatic test_filter();
    int n_evt;
    bit bad;
    async_in[2] = 1'b0;
    repeat (10) tick();
    // 3-cycle glitch: must be rejected.
    bad = 1'b0;
    async_in[2] = 1'b1;
    repeat (3) tick();
    async_in[2] = 1'b0;
    repeat (10) begin
      tick();
      if (sync_out[2] !== 1'b0 || evt_pulse[2] !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL filter_glitch: got a change on ch2, expected none");
    else n_pass++;
    // 4-cycle pulse: must be accepted at edge S+FL with one strobe.
    n_evt = 0;
    async_in[2] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == FL) async_in[2] = 1'b0;
      if (evt_pulse[2] === 1'b1) n_evt++;
      if (e == S + FL) begin
        n_checks++;
        if (!(sync_out[2] === 1'b1 && evt_pulse[2] === 1'b1))
          $display("FAIL filter_accept: got sync %b evt %b expected 1 1", sync_out[2], evt_pulse[2]);
        else n_pass++;
      end
      n_checks++;
      if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
        $display("FAIL filter_model e%0d: got %b expected %b", e,
                 {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
      else n_pass++;
    end
    n_checks++;
    if (n_evt != 1) $display("FAIL filter_evt_count: got %0d expected 1", n_evt);
    else n_pass++;
  endtask

  task automatic test_toggle();
    int n_evt;
    int n_fall;
    n_evt  = 0;
    n_fall = 0;
    for (int t = 0; t < 5; t++) begin
      async_in[3] = ~async_in[3];
      repeat (6) begin
        tick();
        if (evt_pulse[3] === 1'b1) n_evt++;
        if (fall_pulse[3] !== 1'b0) n_fall++;
        n_checks++;
        if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
          $display("FAIL toggle_model t%0d: got %b expected %b", t,
                   {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
        else n_pass++;
      end
    end
    n_checks++;
    if (n_evt != 5 || n_fall != 0)
      $display("FAIL toggle_count: got evt %0d fall %0d expected 5 0", n_evt, n_fall);
    else n_pass++;
  endtask

`ifdef RIFL_SYNC_EVENT_CNT_EN
  task automatic test_counter();
    bit seen;
    evt_cnt_clr = 1'b1;
    tick();
    evt_cnt_clr = 1'b0;
    for (int n = 0; n < 17; n++) begin
      async_in[0] = 1'b1;
      repeat (3) tick();
      async_in[0] = 1'b0;
      repeat (3) tick();
    end
    repeat (6) tick();
    n_checks++;
    if (evt_cnt[CW-1:0] !== 4'hF) $display("FAIL cnt_saturate: got %0d expected 15", evt_cnt[CW-1:0]);
    else n_pass++;
    n_checks++;
    if (evt_cnt !== {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]})
      $display("FAIL cnt_model: got %h expected %h", evt_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
    else n_pass++;
    // Clear while the strobe is visible: the event is lost and the count is 0.
    async_in[0] = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 10 && !seen; w++) begin
      tick();
      if (evt_pulse[0] === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL cnt_clr_wait: got no evt_pulse[0] within 10 cycles, expected one");
    end else begin
      n_pass++;
      evt_cnt_clr = 1'b1;
      tick();
      evt_cnt_clr = 1'b0;
      tick();
      n_checks++;
      if (evt_cnt[CW-1:0] !== 4'h0) $display("FAIL cnt_clr_priority: got %0d expected 0", evt_cnt[CW-1:0]);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) async_in = 4'($urandom);
`ifdef RIFL_SYNC_EVENT_CNT_EN
      evt_cnt_clr = ($urandom_range(0, 31) == 0);
`endif
      tick();
      n_checks++;
      if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
        $display("FAIL random_model c%0d: got %b expected %b", c,
                 {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
      else n_pass++;
`ifdef RIFL_SYNC_EVENT_CNT_EN
      n_checks++;
      if (evt_cnt !== {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]})
        $display("FAIL random_cnt c%0d: got %h expected %h", c, evt_cnt,
                 {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
      else n_pass++;
`endif
    end
`ifdef RIFL_SYNC_EVENT_CNT_EN
    evt_cnt_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_filter();
    bit bad;
    async_in = 4'b0000;
    repeat (12) tick();
    async_in[2] = 1'b1;
    repeat (S + 2) tick();
    rst_n_in = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {RSTV, 4'b0, 4'b0, 1'b0})
      $display("FAIL midfilter_async_reset: got %b/%b/%b/%b expected %b/0000/0000/0",
               sync_out, evt_pulse, fall_pulse, any_evt, RSTV);
    else n_pass++;
    repeat (2) @(negedge clk_in);
    async_in = RSTV | 4'b0100;
    rst_n_in = 1'b1;
    bad = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e < S + FL && ((evt_pulse | fall_pulse) !== 4'b0 || sync_out !== RSTV)) bad = 1'b1;
      if (e == S + FL) begin
        n_checks++;
        if (!(sync_out[2] === 1'b1 && evt_pulse[2] === 1'b1))
          $display("FAIL midfilter_restart: got sync %b evt %b expected 1 1", sync_out[2], evt_pulse[2]);
        else n_pass++;
      end
      n_checks++;
      if ({sync_out, evt_pulse, fall_pulse, any_evt} !== {m_stable, m_evt, m_fall, m_any})
        $display("FAIL midfilter_model e%0d: got %b expected %b", e,
                 {sync_out, evt_pulse, fall_pulse, any_evt}, {m_stable, m_evt, m_fall, m_any});
      else n_pass++;
    end
    n_checks++;
    if (bad) $display("FAIL midfilter_no_pulse: got early pulse or change, expected none");
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_level();
    test_filter();
    test_toggle();
`ifdef RIFL_SYNC_EVENT_CNT_EN
    test_counter();
`endif
    test_random();
    test_reset_mid_filter();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rifl_sync_bank.md
Name: rifl_sync_bank

Overview:
- Parametrised multi-channel CDC receiver that brings NUM_CH asynchronous status/event bits into one destination clock domain.
- Successor to the fixed per-signal bit-synchroniser instances in the RIFL helper: one block per destination domain (init, tx or rx) replaces many single-bit instances.
- Adds configurable synchroniser depth, optional per-channel glitch filtering, toggle-encoded event channels and edge-pulse outputs.

Parameters:
- NUM_CH, 8, number of channels (>=1).
- SYNC_STAGES, 2, flip-flops in each metastability chain (>=2).
- FILTER_LEN, 4, consecutive cycles a new value must hold before it is accepted on filtered channels (>=1).
- FILTER_MASK, 0, NUM_CH-bit mask; bit i=1 enables the filter on channel i.
- TOGGLE_MASK, 0, NUM_CH-bit mask; bit i=1 means channel i carries a toggle-encoded event, not a level.
- RST_VAL, 0, NUM_CH-bit reset value of every chain/stable register per channel.
- CNT_W, 16, event-counter width; used only with RIFL_SYNC_EVENT_CNT_EN.

Ports:
- clk_in  input  1  destination clock.
- rst_n_in  input  1  asynchronous active-low reset; assertion is asynchronous, deassertion is synchronous to clk_in.
- async_in  input  NUM_CH  asynchronous source bits, each from another domain.
- sync_out  output  NUM_CH  stable synchronised level per channel.
- evt_pulse  output  NUM_CH  1-cycle event strobe: rising edge on level channels, any edge on toggle channels.
- fall_pulse  output  NUM_CH  1-cycle falling-edge strobe on level channels; constant 0 on toggle channels.
- any_evt  output  1  registered OR of evt_pulse|fall_pulse, delayed by one cycle.
- evt_cnt_clr  input  1  synchronous clear of all event counters (feature only).
- evt_cnt  output  NUM_CH*CNT_W  per-channel event counts, channel i at [i*CNT_W +: CNT_W] (feature only).

Behaviour:
- Reset (rst_n_in=0):
  - Every chain stage and the stable register of channel i = RST_VAL[i].
  - Filter counters = 0; evt_pulse, fall_pulse, any_evt = 0; evt_cnt = 0.
  - No pulse is produced on reset deassertion, even when async_in differs from RST_VAL.
  - Reset asserted mid-filter discards the partial count.
- Chain: async_in[i] is sampled at the first clk_in edge into stage 1. The last stage (s_q) holds the value after SYNC_STAGES edges. No logic is allowed between stages.
- Unfiltered channel: stable <= s_q. sync_out changes SYNC_STAGES+1 edges after a clean input change. This latency is fixed.
- Filtered channel:
  - If s_q == stable, the counter is cleared to 0.
  - Otherwise the counter increments. When counter == FILTER_LEN-1 and s_q != stable, stable <= s_q and the counter is cleared.
  - Latency is SYNC_STAGES+FILTER_LEN edges.
  - A mismatch lasting fewer than FILTER_LEN cycles at s_q is rejected with no change and no pulse.
  - Counter width is clog2(FILTER_LEN+1).
- Pulses are registered together with stable:
  - evt_pulse[i] is 1 in exactly the cycle the new stable value first appears.
  - Level channel: evt_pulse on 0->1, fall_pulse on 1->0.
  - Toggle channel: evt_pulse on any change.
  - Back-to-back changes on consecutive cycles (unfiltered) give pulses on consecutive cycles.
  - On toggle channels the source must not toggle faster than once per SYNC_STAGES+1 destination cycles; faster toggling may merge events (documented limitation, not detected).
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- sync_out is the stable register directly: glitch-free, with no combinational path from async_in.

Optional Feature:
- Macro: RIFL_SYNC_EVENT_CNT_EN.
- When defined:
  - Each channel has a CNT_W-bit counter that increments on evt_pulse[i] and saturates at all-ones.
  - evt_cnt_clr=1 zeroes all counters. Clear has priority over an increment in the same cycle: result is 0, and the event is lost.
- When undefined: evt_cnt_clr and evt_cnt are absent and no counter logic exists.

Decomposition:
- Package rifl_sync_pkg:
  - clog2 function.
  - MIN_SYNC_STAGES=2 constant.
  - Elaboration-time parameter checks (SYNC_STAGES>=2, FILTER_LEN>=1, NUM_CH>=1).
- Sub-module rifl_sync_chan: one channel (chain, filter, stable, pulses, optional counter), with per-channel FILTER_EN, TOGGLE and RST_BIT parameters.
- The top module generates NUM_CH instances and forms any_evt.

Test Plan:
- NUM_CH=4, RST_VAL=4'b0010, async_in=4'b1101 during reset, then release -> sync_out=0010 until settled, then 1101 at edge SYNC_STAGES+1; no evt_pulse/fall_pulse on the first cycle after release.
- Unfiltered level channel, async_in 0->1, SYNC_STAGES=3 -> sync_out=1 and evt_pulse=1 for exactly one cycle at edge 4; any_evt=1 at edge 5; 1->0 gives fall_pulse.
- Filtered channel, FILTER_LEN=4: 3-cycle high glitch at s_q -> no change and no pulse; 4-cycle high -> sync_out=1 at edge SYNC_STAGES+4 with one evt_pulse.
- Toggle channel, source toggles 5 times spaced 6 cycles apart -> 5 evt_pulse strobes, fall_pulse stays 0.
- Feature on, CNT_W=4: 17 events -> evt_cnt saturates at 15; evt_cnt_clr coincident with an event -> count 0.
- Reset asserted mid-filter at count 2 -> counter 0, sync_out=RST_VAL immediately (asynchronous), no pulse after release.
